// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU host sequencer: FSM state encoding,
// default bus width and the ALU op-codes.
package alu_seq_pkg;

  localparam int ALU_DATA_W = 8;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_MUL = 2'b10;
  localparam logic [1:0] ALU_OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_LOAD_Y = 3'd2,
    S_WAIT   = 3'd3,
    S_CAP_LO = 3'd4,
    S_RESP   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/alu_seq_watchdog.sv
// WAIT-state watchdog: counts WAIT cycles and flags expiry on the cycle the
// count reaches TIMEOUT_CYC. Only instantiated when ALU_SEQ_TIMEOUT_EN is defined.
module alu_seq_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Expiry is flagged during the WAIT cycle whose increment would reach the limit.
  assign expired = enable && (count_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_host_sequencer.sv
// Initiator-side sequencer for the multi-cycle ALU: takes one (op, X, Y) request,
// streams it onto the ALU bus, collects the two result bytes and returns them.
// Optional WAIT watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_host_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = ALU_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_W-1:0]     req_x,
  input  logic [DATA_W-1:0]     req_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_data,
  output logic                  rsp_timeout,
  output logic [DATA_W-1:0]     alu_inbus,
  output logic [1:0]            alu_op,
  output logic                  alu_start,
  input  logic [DATA_W-1:0]     alu_outbus,
  input  logic                  alu_finish,
  output logic                  busy
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("alu_host_sequencer: TIMEOUT_CYC must be at least 1");
  end

  seq_state_e            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_W-1:0]     x_q, x_d;
  logic [DATA_W-1:0]     y_q, y_d;
  logic [2*DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                  timeout_hit;

  // NOTE: every signal gets its default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          x_d     = req_x;
          y_d     = req_y;
          state_d = S_START;
        end
      end
      S_START:  state_d = S_LOAD_Y;
      S_LOAD_Y: state_d = S_WAIT;
      S_WAIT: begin
        // A real finish on the expiry cycle still wins over the watchdog.
        if (alu_finish) begin
          rsp_data_d[2*DATA_W-1:DATA_W] = alu_outbus;
          state_d                       = S_CAP_LO;
        end else if (timeout_hit) begin
          rsp_data_d = '0;
          state_d    = S_RESP;
        end
      end
      S_CAP_LO: begin
        rsp_data_d[DATA_W-1:0] = alu_outbus;
        state_d                = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so nothing on the host or ALU
  // side has a combinational path back through the sequencer.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    alu_start = 1'b0;
    alu_inbus = '0;
    alu_op    = 2'b00;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_START: begin
        alu_start = 1'b1;
        alu_inbus = x_q;
        alu_op    = op_q;
      end
      S_LOAD_Y: begin
        alu_inbus = y_q;
        alu_op    = op_q;
      end
      S_WAIT, S_CAP_LO: alu_op = op_q;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_data = rsp_data_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      x_q        <= '0;
      y_q        <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  logic timeout_q, timeout_d;

  // Count is cleared in LOAD_Y so it starts from zero on the first WAIT cycle.
  alu_seq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == S_LOAD_Y),
    .enable  (state_q == S_WAIT),
    .expired (timeout_hit)
  );

  always_comb begin
    timeout_d = timeout_q;
    if (state_q == S_WAIT && !alu_finish && timeout_hit) begin
      timeout_d = 1'b1;
    end else if (state_q == S_RESP && rsp_ready) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign rsp_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Self-checking bench for alu_host_sequencer with a behavioural ALU model and
// a response scoreboard. Timeout scenario runs when ALU_SEQ_TIMEOUT_EN is defined.
module tb_alu_host_sequencer;
  import alu_seq_pkg::*;

  localparam int W       = 8;
  localparam int FIN_DLY = 10;

  typedef struct packed {
    logic [2*W-1:0] data;
    logic           to;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid, req_ready;
  logic [1:0]     req_op;
  logic [W-1:0]   req_x, req_y;
  logic           rsp_valid, rsp_ready;
  logic [2*W-1:0] rsp_data;
  logic           rsp_timeout;
  logic [W-1:0]   alu_inbus;
  logic [1:0]     alu_op;
  logic           alu_start;
  logic [W-1:0]   alu_outbus;
  logic           alu_finish;
  logic           busy;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   fin_cyc  = 0;
  int   last_acc = -100;
  exp_t sb[$];

  logic spurious     = 1'b0;
  logic never_finish = 1'b0;

  alu_host_sequencer #(.DATA_W(W), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_x       (req_x),
    .req_y       (req_y),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .alu_inbus   (alu_inbus),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_outbus  (alu_outbus),
    .alu_finish  (alu_finish),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Arbitrary but operand- and op-sensitive result, so swapped or stale bytes show up.
  function automatic logic [2*W-1:0] alu_res(logic [1:0] op, logic [W-1:0] x, logic [W-1:0] y);
    return {x ^ 8'hB9 ^ {6'b0, op}, y ^ 8'hF9 ^ {op, 6'b0}};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s: observed=no event expected=event within bound", tag);
  endtask

  // Behavioural ALU: captures X on start, Y next cycle, finish FIN_DLY cycles after start.
  logic [1:0]   m_op;
  logic [W-1:0] m_x, m_y;
  logic         m_active = 1'b0;
  int           m_k      = 0;
  always @(negedge clk) begin
    if (!rst) begin
      m_active   = 1'b0;
      alu_finish = 1'b0;
      alu_outbus = '0;
    end else begin
      alu_finish = 1'b0;
      alu_outbus = '0;
      if (alu_start) begin
        m_active = 1'b1;
        m_k      = 0;
        m_op     = alu_op;
        m_x      = alu_inbus;
      end else if (m_active) begin
        m_k++;
        if (m_k == 1) begin
          m_y = alu_inbus;
          if (spurious) begin
            alu_finish = 1'b1;
            alu_outbus = 8'hEE;
          end
        end
        if (!never_finish && m_k == FIN_DLY) begin
          alu_finish = 1'b1;
          alu_outbus = alu_res(m_op, m_x, m_y)[2*W-1:W];
          fin_cyc    = cyc;
        end else if (!never_finish && m_k == FIN_DLY + 1) begin
          alu_outbus = alu_res(m_op, m_x, m_y)[W-1:0];
          m_active   = 1'b0;
        end
      end
    end
  end

  // Monitor: samples late in the low phase, after all negedge drivers have settled.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      if (rsp_valid && rsp_ready) begin
        last_acc = cyc;
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL rsp_unexpected: observed=%0h expected=no response", rsp_data);
        end
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_timeout", rsp_timeout, e.to);
        end
      end
      if (alu_start) check("start_gap_ok", (cyc - last_acc) >= 2, 1);
    end
  end

  // Drives a request from a negedge; returns on the negedge of the START cycle.
  task automatic send(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                      input exp_t e);
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_y     = y;
    sb.push_back(e);
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        @(negedge clk);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    fail_timeout("req_accept");
  endtask

  task automatic send_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.data = alu_res(op, x, y);
    e.to   = 1'b0;
    send(op, x, y, e);
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) return;
      @(negedge clk);
    end
    fail_timeout(tag);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !busy) return;
      @(negedge clk);
    end
    fail_timeout(tag);
  endtask

  int s_cyc;
  logic [2*W-1:0] held;

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_alu_inbus", alu_inbus, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);

    // Basic transaction
    send_op(ALU_OP_ADD, 8'h12, 8'h34);
    s_cyc = cyc;
    check("basic_start", alu_start, 1);
    check("basic_inbus_x", alu_inbus, 8'h12);
    check("basic_op", alu_op, ALU_OP_ADD);
    check("basic_req_ready", req_ready, 0);
    check("basic_busy", busy, 1);
    @(negedge clk);
    check("basic_start_pulse", alu_start, 0);
    check("basic_inbus_y", alu_inbus, 8'h34);
    @(negedge clk);
    check("basic_inbus_wait", alu_inbus, 0);
    check("basic_op_wait", alu_op, ALU_OP_ADD);
    wait_rsp("basic_rsp");
    check("basic_rsp_latency", cyc - s_cyc, FIN_DLY + 2);
    check("basic_fin_to_valid", cyc - fin_cyc, 2);
    check("basic_rsp_abcd", rsp_data, 16'hABCD);
    check("basic_op_resp", alu_op, 0);
    @(negedge clk);
    check("basic_rsp_done", rsp_valid, 0);
    wait_drain("basic_drain");

    // Back-pressure with a pending request
    rsp_ready = 1'b0;
    send_op(ALU_OP_SUB, 8'h55, 8'h66);
    wait_rsp("bp_rsp");
    held      = alu_res(ALU_OP_SUB, 8'h55, 8'h66);
    req_valid = 1'b1;
    req_op    = ALU_OP_MUL;
    req_x     = 8'h9C;
    req_y     = 8'h3E;
    for (int i = 0; i < 20; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, held);
      check("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    begin
      exp_t e;
      e.data = alu_res(ALU_OP_MUL, 8'h9C, 8'h3E);
      e.to   = 1'b0;
      sb.push_back(e);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_bubble_idle", req_ready, 1);
    check("bp_bubble_start", alu_start, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_pending_start", alu_start, 1);
    check("bp_pending_x", alu_inbus, 8'h9C);
    wait_drain("bp_drain");

    // Spurious finish during LOAD_Y
    spurious = 1'b1;
    send_op(ALU_OP_DIV, 8'hA5, 8'h5A);
    wait_rsp("spur_rsp");
    spurious = 1'b0;
    wait_drain("spur_drain");

    // Back-to-back queued requests
    for (int i = 0; i < 4; i++) begin
      send_op(2'(i), 8'(i), 8'(2 * i));
    end
    wait_drain("b2b_drain");

`ifdef ALU_SEQ_TIMEOUT_EN
    // Watchdog expiry, then a normal transaction
    never_finish = 1'b1;
    begin
      exp_t e;
      e.data = '0;
      e.to   = 1'b1;
      send(ALU_OP_ADD, 8'h11, 8'h22, e);
    end
    s_cyc = cyc;
    wait_rsp("to_rsp");
    check("to_latency", cyc - s_cyc, 2 + 16);
    check("to_flag", rsp_timeout, 1);
    check("to_data", rsp_data, 0);
    never_finish = 1'b0;
    wait_drain("to_drain");
    send_op(ALU_OP_SUB, 8'h21, 8'h43);
    wait_drain("to_next_drain");
`endif

    // Reset asserted mid-WAIT
    send_op(ALU_OP_DIV, 8'h77, 8'h88);
    repeat (4) @(negedge clk);
    check("mid_busy_before", busy, 1);
    rst = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_alu_op", alu_op, 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    check("mid_no_partial_rsp", rsp_valid, 0);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
